// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with direct-decode and prescaled auto-scan modes.
// Latency: 1 clk from a/mode/en to bcode/idx; step/wrap are single-cycle pulses on the advance edge.
// Backpressure: none; en=0 blanks bcode and freezes idx and the prescaler in place.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   en       enable; 0 blanks bcode, freezes idx and prescaler
//   mode     0 = direct decode of a, 1 = scan
//   a        address for direct mode (N bits)
//   mask     (only with DECODER_SCAN_MASK_EN) 2^N bits, bit i=1 skips line i
//   bcode    registered one-hot (or all-zero) output, 2^N bits
//   idx      registered index currently selected
//   step     one-cycle pulse when the scan index advances
//   wrap     one-cycle pulse when the new scan index is <= the old one
//
// Optional build macro: DECODER_SCAN_MASK_EN adds the mask input. Without it the
// design behaves exactly as if mask were tied to all-zeros.

module decoder_scan #(
    parameter int N        = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        a,
`ifdef DECODER_SCAN_MASK_EN
    input  logic [(2**N)-1:0]   mask,
`endif
    output logic [(2**N)-1:0]   bcode,
    output logic [N-1:0]        idx,
    output logic                step,
    output logic                wrap
);

    localparam int LINES = 2**N;
    // Prescaler is at least one bit wide so PRESCALE=1 still has a legal register.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);

    logic [LINES-1:0] bcode_q, bcode_d;
    logic [N-1:0]     idx_q, idx_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic [PW-1:0]    pre_q, pre_d;

    // Lines to skip while scanning or to blank in direct mode.
    logic [LINES-1:0] skip;
`ifdef DECODER_SCAN_MASK_EN
    assign skip = mask;
`else
    assign skip = '0;
`endif

    function automatic logic [LINES-1:0] onehot(input logic [N-1:0] v);
        logic [LINES-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    // Modular search for the next unskipped line after idx_q. The last
    // candidate (offset LINES truncates to 0) is idx_q itself, so the
    // current line is eligible only after every other line.
    logic [N-1:0] nxt;
    logic [N-1:0] cand;
    logic         nxt_vld;

    always_comb begin
        nxt     = idx_q;
        cand    = '0;
        nxt_vld = 1'b0;
        for (int i = 1; i <= LINES; i++) begin
            cand = idx_q + N'(i);
            if (!nxt_vld && !skip[cand]) begin
                nxt     = cand;
                nxt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        bcode_d = '0;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        if (!en) begin
            // Blank only; idx and prescaler keep their values so a scan
            // resumes exactly where it left off.
            bcode_d = '0;
        end else if (!mode) begin
            pre_d   = '0;
            idx_d   = a;
            bcode_d = skip[a] ? '0 : onehot(a);
        end else if (pre_q == PRE_TOP) begin
            pre_d = '0;
            if (nxt_vld) begin
                idx_d   = nxt;
                bcode_d = onehot(nxt);
                step_d  = 1'b1;
                wrap_d  = (nxt <= idx_q);
            end else begin
                // Every line masked: hold idx, stay dark, no pulses.
                bcode_d = '0;
            end
        end else begin
            pre_d   = pre_q + PW'(1);
            // A line masked mid-dwell goes dark until the next step.
            bcode_d = skip[idx_q] ? '0 : onehot(idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcode_q <= '0;
            idx_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
        end else begin
            bcode_q <= bcode_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
        end
    end

    assign bcode = bcode_q;
    assign idx   = idx_q;
    assign step  = step_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N=4, PRESCALE=4
    logic        rst_n, en, mode;
    logic [3:0]  a;
    logic [15:0] mask;
    logic [15:0] bcode;
    logic [3:0]  idx;
    logic        step, wrap;

    // DUT B: N=4, PRESCALE=1
    logic        rst_b_n, en_b, mode_b;
    logic [3:0]  a_b;
    logic [15:0] mask_b;
    logic [15:0] bcode_b;
    logic [3:0]  idx_b;
    logic        step_b, wrap_b;

    int checks   = 0;
    int failures = 0;

    decoder_scan #(.N(4), .PRESCALE(4)) u_dut (
        .clk     (clk),
        .reset_n (rst_n),
        .en      (en),
        .mode    (mode),
        .a       (a),
`ifdef DECODER_SCAN_MASK_EN
        .mask    (mask),
`endif
        .bcode   (bcode),
        .idx     (idx),
        .step    (step),
        .wrap    (wrap)
    );

    decoder_scan #(.N(4), .PRESCALE(1)) u_dut_p1 (
        .clk     (clk),
        .reset_n (rst_b_n),
        .en      (en_b),
        .mode    (mode_b),
        .a       (a_b),
`ifdef DECODER_SCAN_MASK_EN
        .mask    (mask_b),
`endif
        .bcode   (bcode_b),
        .idx     (idx_b),
        .step    (step_b),
        .wrap    (wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oh(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; a = '0; mask = '0;
        rst_b_n = 1'b0; en_b = 1'b1; mode_b = 1'b1; a_b = '0; mask_b = '0;

        // 1. Reset held for 3 cycles in scan mode
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_bcode", 32'(bcode), 32'h0);
            check("rst_idx",   32'(idx),   32'h0);
            check("rst_step",  32'(step),  32'h0);
            check("rst_wrap",  32'(wrap),  32'h0);
        end
        rst_n = 1'b1;

        // 3. Scan from reset, 16 steps with wrap on the last
        for (int s = 1; s <= 16; s++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c < 4) begin
                    check("scan_dwell_step",  32'(step),  32'h0);
                    check("scan_dwell_bcode", 32'(bcode), 32'(oh((s - 1) % 16)));
                end else begin
                    check("scan_step",  32'(step),  32'h1);
                    check("scan_idx",   32'(idx),   32'(s % 16));
                    check("scan_bcode", 32'(bcode), 32'(oh(s % 16)));
                    check("scan_wrap",  32'(wrap),  32'((s == 16) ? 1 : 0));
                end
            end
        end

        // 1b. Reset mid-scan at idx=7, mid-dwell
        repeat (7 * 4 + 2) tick();
        check("pre_midrst_idx", 32'(idx), 32'h7);
        rst_n = 1'b0;
        tick();
        check("midrst_bcode", 32'(bcode), 32'h0);
        check("midrst_idx",   32'(idx),   32'h0);
        check("midrst_step",  32'(step),  32'h0);
        check("midrst_wrap",  32'(wrap),  32'h0);
        rst_n = 1'b1;

        // 4. Freeze at idx=5, prescaler=2
        repeat (5 * 4 + 2) tick();
        check("frz_pre_bcode", 32'(bcode), 32'h0020);
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("frz_bcode", 32'(bcode), 32'h0);
            check("frz_idx",   32'(idx),   32'h5);
            check("frz_step",  32'(step),  32'h0);
        end
        en = 1'b1;
        tick();
        check("unfrz1_bcode", 32'(bcode), 32'h0020);
        check("unfrz1_step",  32'(step),  32'h0);
        tick();
        check("unfrz2_step",  32'(step),  32'h1);
        check("unfrz2_idx",   32'(idx),   32'h6);
        check("unfrz2_bcode", 32'(bcode), 32'h0040);

        // 5. Mode switch: scan to idx=3, direct a=9, back to scan
        do_reset();
        repeat (3 * 4) tick();
        check("ms_idx3", 32'(idx), 32'h3);
        mode = 1'b0; a = 4'd9;
        tick();
        check("ms_dir_bcode", 32'(bcode), 32'h0200);
        check("ms_dir_idx",   32'(idx),   32'h9);
        check("ms_dir_step",  32'(step),  32'h0);
        mode = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("ms_dwell_step",  32'(step),  32'h0);
            check("ms_dwell_bcode", 32'(bcode), 32'h0200);
        end
        tick();
        check("ms_step",  32'(step),  32'h1);
        check("ms_idx",   32'(idx),   32'd10);
        check("ms_bcode", 32'(bcode), 32'h0400);
        check("ms_wrap",  32'(wrap),  32'h0);

        // 2. Direct sweep a=0..15, then blank
        mode = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a = 4'(k);
            tick();
            check("dir_bcode", 32'(bcode), 32'(oh(k)));
            check("dir_idx",   32'(idx),   32'(k));
            check("dir_step",  32'(step),  32'h0);
            check("dir_wrap",  32'(wrap),  32'h0);
        end
        en = 1'b0;
        tick();
        check("dir_blank_bcode", 32'(bcode), 32'h0);
        check("dir_blank_idx",   32'(idx),   32'hF);
        en = 1'b1;

        // 3b. PRESCALE=1: advance every cycle, step held high
        rst_b_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("p1_idx",   32'(idx_b),   32'(k % 16));
            check("p1_step",  32'(step_b),  32'h1);
            check("p1_bcode", 32'(bcode_b), 32'(oh(k % 16)));
            check("p1_wrap",  32'(wrap_b),  32'(((k % 16) == 0) ? 1 : 0));
        end

`ifdef DECODER_SCAN_MASK_EN
        // 6. Mask: only lines 0 and 15 eligible
        mode = 1'b1;
        mask = 16'h7FFE;
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            repeat (3) tick();
            check("mk_dwell_step", 32'(step), 32'h0);
            tick();
            check("mk_step",  32'(step),  32'h1);
            check("mk_idx",   32'(idx),   32'((s % 2 == 1) ? 15 : 0));
            check("mk_bcode", 32'(bcode), 32'((s % 2 == 1) ? 16'h8000 : 16'h0001));
            check("mk_wrap",  32'(wrap),  32'((s % 2 == 0) ? 1 : 0));
        end
        mask = 16'hFFFF;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("mk_all_bcode", 32'(bcode), 32'h0);
            check("mk_all_step",  32'(step),  32'h0);
            check("mk_all_idx",   32'(idx),   32'h0);
        end
        mask = 16'h7FFE;
        mode = 1'b0; a = 4'd1;
        tick();
        check("mk_dir_idx",   32'(idx),   32'h1);
        check("mk_dir_bcode", 32'(bcode), 32'h0);
        a = 4'd0;
        tick();
        check("mk_dir0_bcode", 32'(bcode), 32'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
Parametrised, registered N-to-2^N one-hot decoder with two modes: direct decode of a binary address, and autonomous scan that steps a one-hot output through all lines at a prescaled rate. It is the successor to the combinational 4-to-16 decoder. It drives digit/anode enables, LED multiplexing and round-robin select lines on the prototyping board. All outputs are registered, and bcode is always zero or one-hot.

Parameters:
N, 4, address width; output width is 2^N; legal range 1..6
PRESCALE, 50000, clock cycles per scan step in scan mode; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous reset, active-low
en  in  1  enable; 0 blanks bcode and freezes the scan state
mode  in  1  0 = direct decode, 1 = scan
a  in  N  address for direct mode
bcode  out  2^N  registered one-hot output; all-zero when blanked
idx  out  N  registered index currently selected
step  out  1  one-cycle pulse when the scan index advances
wrap  out  1  one-cycle pulse when the scan index wraps (new idx <= old idx)

Behaviour:
- Reset: one clock and reset only. Reset is synchronous and active-low: on any rising clk edge with reset_n=0, bcode=0, idx=0, step=0, wrap=0, and the internal prescaler is 0. Reset overrides all other inputs, including mid-scan.
- Direct mode (mode=0, en=1):
  - Each edge: idx<=a, bcode<=1<<a.
  - Latency is 1 cycle. step and wrap are 0. Prescaler is held at 0.
- Scan mode (mode=1, en=1):
  - Prescaler counts 0..PRESCALE-1.
  - On the edge where prescaler==PRESCALE-1: prescaler<=0, idx<=next index, bcode<=one-hot(next index), step<=1.
  - If next index <= old idx, wrap<=1 in the same cycle.
  - On all other edges: step and wrap are 0, and bcode=one-hot(idx).
- Next index: without the mask feature, next index = (idx+1) mod 2^N, so 2^N-1 wraps to 0.
- PRESCALE=1: the index advances every cycle and step stays high continuously.
- en=0 (either mode):
  - bcode<=0 on the next edge; step and wrap are 0.
  - idx and prescaler hold their values.
  - When en returns in scan mode, counting resumes from the frozen prescaler value. No step is lost or duplicated.
- Mode change 0->1: scan starts from the current idx with the prescaler at 0. The first step occurs PRESCALE cycles later.
- Mode change 1->0: the next edge performs a direct decode of a, and the prescaler clears.
- Invariant: bcode is never multi-hot, including on mode and en transitions.
- Internal state: prescaler width is clog2(PRESCALE) (minimum 1). All arithmetic is unsigned and modulo its width.

Optional Feature:
Macro DECODER_SCAN_MASK_EN.
- Defined:
  - Adds input port mask, 2^N bits wide; bit i=1 means skip line i.
  - Scan next index is the first index after idx, searching modularly, whose mask bit is 0. idx itself is eligible last.
  - If all mask bits are 1: bcode=0, idx holds, step=0, wrap=0; the prescaler keeps counting.
  - If the current idx becomes masked during a dwell, bcode<=0 on the next edge until the next step.
  - Direct mode: when mask[a]=1, idx<=a and bcode<=0.
- Undefined: no mask port; behaviour is identical to mask=0.

Test Plan:
1. Reset: N=4, PRESCALE=4, en=1, mode=1, reset_n=0 for 3 cycles -> bcode=0, idx=0, step=0, wrap=0. Assert reset_n=0 again mid-scan at idx=7 -> all outputs return to 0 on that edge.
2. Direct sweep: mode=0, en=1, a=0..15, one value per cycle -> bcode=16'h0001<<a and idx=a one cycle later; step stays 0. Drop en -> bcode=16'h0000 next cycle, idx holds 15.
3. Scan: PRESCALE=4, mode=1, en=1 from reset -> bcode=16'h0001, then step pulses every 4 cycles with idx 1,2,...,15, 0. The 16th step raises wrap with bcode=16'h0001. PRESCALE=1 variant -> idx increments every cycle and step stays high.
4. Freeze: in scan at idx=5, prescaler=2, drop en for 10 cycles -> bcode=0, idx=5, no step. Re-enable -> bcode=16'h0020, then step to idx=6 after exactly 2 more cycles.
5. Mode switch: scan at idx=3, set mode=0 with a=9 -> bcode=16'h0200 one cycle later. Return to mode=1 -> first step to idx=10 (bcode=16'h0400) after 4 cycles.
6. Mask (macro defined): mask=16'h7FFE -> scan alternates idx 0,15,0,15 with wrap on every 15->0 step. mask=16'hFFFF -> bcode=0, no step. Direct mode a=1 with mask[1]=1 -> idx=1, bcode=0.
